// File: rtl/writeback_arbiter.sv
// Write-side driver for the 32x32 register file. Merges the single-cycle ALU
// result path (priority) with a FIFO-buffered load/mul path, drops x0 writes,
// kills queued results made stale by a younger ALU write, bounds FIFO
// starvation, and forwards the in-flight write to the decode read ports.
module writeback_arbiter #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                       CLK,
   input  logic                       rstControl,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [4:0]                 alu_rd,
   input  logic [XLEN-1:0]            alu_data,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [4:0]                 mem_rd,
   input  logic [XLEN-1:0]            mem_data,
   output logic                       WE,
   output logic [4:0]                 rd,
   output logic [XLEN-1:0]            writeBack,
   input  logic [4:0]                 rs,
   input  logic [4:0]                 rt,
   input  logic [XLEN-1:0]            A_rf,
   input  logic [XLEN-1:0]            B_rf,
   output logic [XLEN-1:0]            A,
   output logic [XLEN-1:0]            B,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   // Load/mul FIFO storage; the kill bit travels with each entry.
   logic [4:0]       fifo_rd_q   [DEPTH];
   logic [XLEN-1:0]  fifo_data_q [DEPTH];
   logic [DEPTH-1:0] fifo_kill_q;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
   logic             starve_q, starve_d;

   logic             we_q, we_d;
   logic [4:0]       rd_q, rd_d;
   logic [XLEN-1:0]  wb_q, wb_d;

   logic             alu_acc, push, pop, kill_hit;
   logic             slot_vld, slot_kill;
   logic [4:0]       slot_rd;
   logic [XLEN-1:0]  slot_data;

   assign alu_ready  = !starve_q;
   assign mem_ready  = (count_q != CW'(DEPTH));
   assign fifo_count = count_q;

   assign alu_acc  = alu_valid && alu_ready;
   assign push     = mem_valid && mem_ready;
   assign pop      = !alu_acc && (count_q != '0);
   // An ALU write to a real register makes any queued result for it stale.
   assign kill_hit = alu_acc && (alu_rd != 5'd0);

   // Arbitration: pick this cycle's write slot and the next control state.
   always_comb begin
      slot_vld  = alu_acc || pop;
      slot_rd   = alu_acc ? alu_rd   : fifo_rd_q[rd_ptr_q];
      slot_data = alu_acc ? alu_data : fifo_data_q[rd_ptr_q];
      slot_kill = !alu_acc && fifo_kill_q[rd_ptr_q];

      we_d = slot_vld && (slot_rd != 5'd0) && !slot_kill;
      rd_d = slot_rd;
      wb_d = slot_data;

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      // Only ALU wins can hold the FIFO off; any pop or an empty FIFO resets the run.
      starve_cnt_d = starve_cnt_q;
      if (pop || (count_q == '0)) starve_cnt_d = '0;
      else if (alu_acc)           starve_cnt_d = starve_cnt_q + SW'(1);
      starve_d = (starve_cnt_d == SW'(STARVE_LIMIT));
   end

   // Control state: pointers, occupancy, starvation tracking.
   always_ff @(posedge CLK) begin
      if (rstControl) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_cnt_q <= '0;
         starve_q     <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_cnt_q <= starve_cnt_d;
         starve_q     <= starve_d;
      end
   end

   // FIFO storage: mark stale entries, then write the incoming entry (same-cycle kill included).
   always_ff @(posedge CLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_hit && (fifo_rd_q[i] == alu_rd)) fifo_kill_q[i] <= 1'b1;
      end
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= mem_rd;
         fifo_data_q[wr_ptr_q] <= mem_data;
         fifo_kill_q[wr_ptr_q] <= kill_hit && (mem_rd == alu_rd);
      end
   end

   // ---- arbitration -> register-file write port ----
   // Output register: one-cycle latency from arbitration to WE/rd/writeBack.
   always_ff @(posedge CLK) begin
      if (rstControl) begin
         we_q <= 1'b0;
         rd_q <= '0;
         wb_q <= '0;
      end else begin
         we_q <= we_d;
         rd_q <= rd_d;
         wb_q <= wb_d;
      end
   end

   assign WE        = we_q;
   assign rd        = rd_q;
   assign writeBack = wb_q;

   // The in-flight write has not reached the file yet, so decode must see it here.
   assign A = (we_q && (rd_q == rs) && (rs != 5'd0)) ? wb_q : A_rf;
   assign B = (we_q && (rd_q == rt) && (rt != 5'd0)) ? wb_q : B_rf;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: acts as the register file, keeps a queue of
// expected writes pushed as stimulus is driven, and compares each WE=1 cycle
// against the head of that queue.
module tb_writeback_arbiter;

   logic        CLK = 1'b0;
   logic        rstControl;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        WE;
   logic [4:0]  rd;
   logic [31:0] writeBack;
   logic [4:0]  rs, rt;
   logic [31:0] A_rf, B_rf, A, B;
   logic [2:0]  fifo_count;

   logic [31:0] regs [32];
   logic [36:0] exp_q [$];
   int          total = 0;
   int          bad   = 0;

   always #5 CLK = ~CLK;

   writeback_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(3)) dut (
      .CLK(CLK), .rstControl(rstControl),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .WE(WE), .rd(rd), .writeBack(writeBack),
      .rs(rs), .rt(rt), .A_rf(A_rf), .B_rf(B_rf), .A(A), .B(B),
      .fifo_count(fifo_count)
   );

   assign A_rf = regs[rs];
   assign B_rf = regs[rt];

   // Register file written one edge after WE is presented.
   always @(posedge CLK) begin
      if (WE === 1'b1 && rd != 5'd0) regs[rd] <= writeBack;
   end

   // Scoreboard: every issued write must match the oldest expected write.
   always @(negedge CLK) begin
      if (WE === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rd, writeBack);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({rd, writeBack} !== e) begin
               bad++;
               $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                        rd, writeBack, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
   endtask

   task automatic test_reset();
      rstControl = 1'b1;
      idle_inputs();
      tick(); tick();
      total++; if (WE !== 1'b0)         begin bad++; $display("FAIL reset_we: got %b required 0", WE); end
      total++; if (rd !== 5'd0)         begin bad++; $display("FAIL reset_rd: got %0d required 0", rd); end
      total++; if (writeBack !== 32'd0) begin bad++; $display("FAIL reset_wb: got %h required 0", writeBack); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
      total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1)
         begin bad++; $display("FAIL reset_ready: got mem=%b alu=%b required 1 1", mem_ready, alu_ready); end
      rstControl = 1'b0;
   endtask

   task automatic test_alu_write();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAAAAAA;
      exp_q.push_back({5'd1, 32'hAAAAAAAA});
      tick();
      alu_valid = 1'b0;
      total++; if (WE !== 1'b1 || rd !== 5'd1 || writeBack !== 32'hAAAAAAAA)
         begin bad++; $display("FAIL alu_latency: got we=%b rd=%0d data=%h required 1 1 aaaaaaaa", WE, rd, writeBack); end
      tick();
      rs = 5'd1; #1;
      total++; if (A !== 32'hAAAAAAAA) begin bad++; $display("FAIL alu_readback: got %h required aaaaaaaa", A); end
   endtask

   task automatic test_x0();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      tick();
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h12345678;
      total++; if (WE !== 1'b0) begin bad++; $display("FAIL x0_alu_we: got %b required 0", WE); end
      tick();
      mem_valid = 1'b0;
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL x0_queued: got %0d required 1", fifo_count); end
      tick();
      total++; if (WE !== 1'b0 || fifo_count !== 3'd0)
         begin bad++; $display("FAIL x0_mem_pop: got we=%b count=%0d required 0 0", WE, fifo_count); end
      rs = 5'd0; #1;
      total++; if (A !== 32'd0) begin bad++; $display("FAIL x0_read: got %h required 0", A); end
   endtask

   task automatic test_fill_wrap();
      int aluidx = 0;
      int pushidx = 0;
      logic starve_exp;
      alu_valid = 1'b1; alu_rd = 5'd20;
      for (int k = 0; k <= 20; k++) begin
         starve_exp = (k >= 4) && (k % 4 == 0);
         alu_data  = 32'hA1000000 + aluidx;
         mem_valid = (k <= 3) || (k == 5);
         mem_rd    = 5'(2 + pushidx);
         mem_data  = 32'hC0DE0000 + 32'(2 + pushidx);
         #1;
         total++; if (alu_ready !== !starve_exp)
            begin bad++; $display("FAIL starve_k%0d: got alu_ready=%b required %b", k, alu_ready, !starve_exp); end
         if (k == 4) begin
            total++; if (fifo_count !== 3'd4 || mem_ready !== 1'b0)
               begin bad++; $display("FAIL fifo_full: got count=%0d ready=%b required 4 0", fifo_count, mem_ready); end
         end
         if (mem_valid) begin
            total++; if (mem_ready !== 1'b1)
               begin bad++; $display("FAIL push_ready_k%0d: got %b required 1", k, mem_ready); end
            pushidx++;
         end
         if (starve_exp) exp_q.push_back({5'(2 + k/4 - 1), 32'hC0DE0000 + 32'(2 + k/4 - 1)});
         else begin
            exp_q.push_back({5'd20, alu_data});
            aluidx++;
         end
         tick();
      end
      idle_inputs();
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL fill_drain: got %0d required 0", fifo_count); end
      tick();
      for (int r = 2; r <= 6; r++) begin
         total++; if (regs[r] !== 32'hC0DE0000 + 32'(r))
            begin bad++; $display("FAIL fill_reg%0d: got %h required %h", r, regs[r], 32'hC0DE0000 + 32'(r)); end
      end
   endtask

   task automatic test_kill();
      // queued entry killed by a later ALU write
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h00000099;
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h00000077;
      exp_q.push_back({5'd9, 32'h00000099});
      tick();
      mem_valid = 1'b0;
      alu_rd = 5'd7; alu_data = 32'h00000070;
      exp_q.push_back({5'd7, 32'h00000070});
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL kill_queued: got %0d required 1", fifo_count); end
      tick();
      alu_valid = 1'b0;
      tick();
      total++; if (WE !== 1'b0 || fifo_count !== 3'd0)
         begin bad++; $display("FAIL kill_pop: got we=%b count=%0d required 0 0", WE, fifo_count); end
      // same-cycle push and ALU write to one register
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22222222;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11111111;
      exp_q.push_back({5'd3, 32'h22222222});
      tick();
      idle_inputs();
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL kill_same_queued: got %0d required 1", fifo_count); end
      tick();
      total++; if (WE !== 1'b0 || fifo_count !== 3'd0)
         begin bad++; $display("FAIL kill_same_pop: got we=%b count=%0d required 0 0", WE, fifo_count); end
      tick();
      total++; if (regs[3] !== 32'h22222222) begin bad++; $display("FAIL kill_r3: got %h required 22222222", regs[3]); end
      total++; if (regs[7] !== 32'h00000070) begin bad++; $display("FAIL kill_r7: got %h required 00000070", regs[7]); end
   endtask

   task automatic test_forward();
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h55555555;
      exp_q.push_back({5'd2, 32'h55555555});
      tick();
      alu_valid = 1'b0;
      rs = 5'd2; rt = 5'd1; #1;
      total++; if (A !== 32'h55555555) begin bad++; $display("FAIL fwd_a: got %h required 55555555", A); end
      total++; if (B !== 32'hAAAAAAAA) begin bad++; $display("FAIL fwd_b_rf: got %h required aaaaaaaa", B); end
      rt = 5'd2; #1;
      total++; if (B !== 32'h55555555) begin bad++; $display("FAIL fwd_b: got %h required 55555555", B); end
      rs = 5'd0; #1;
      total++; if (A !== 32'd0) begin bad++; $display("FAIL fwd_x0: got %h required 0", A); end
      tick();
   endtask

   task automatic test_reset_mid();
      alu_valid = 1'b1; alu_rd = 5'd21;
      for (int k = 0; k < 3; k++) begin
         alu_data  = 32'hB0000000 + 32'(k);
         mem_valid = 1'b1; mem_rd = 5'(10 + k); mem_data = 32'hD0000000 + 32'(k);
         exp_q.push_back({5'd21, alu_data});
         tick();
      end
      idle_inputs();
      rstControl = 1'b1;
      total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL mid_queued: got %0d required 3", fifo_count); end
      tick();
      rstControl = 1'b0;
      total++; if (fifo_count !== 3'd0 || mem_ready !== 1'b1 || WE !== 1'b0)
         begin bad++; $display("FAIL mid_reset: got count=%0d ready=%b we=%b required 0 1 0", fifo_count, mem_ready, WE); end
      tick(); tick();
      total++; if (WE !== 1'b0) begin bad++; $display("FAIL mid_no_write: got %b required 0", WE); end
      for (int r = 10; r <= 12; r++) begin
         total++; if (regs[r] !== 32'd0) begin bad++; $display("FAIL mid_reg%0d: got %h required 0", r, regs[r]); end
      end
      total++; if (regs[21] !== 32'hB0000002) begin bad++; $display("FAIL mid_r21: got %h required b0000002", regs[21]); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      rs = '0; rt = '0;
      idle_inputs();
      rstControl = 1'b1;
      test_reset();
      test_alu_write();
      test_x0();
      test_fill_wrap();
      test_kill();
      test_forward();
      test_reset_mid();
      total++; if (exp_q.size() != 0)
         begin bad++; $display("FAIL missing_writes: got %0d pending required 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
